mb_regfile_ctrl: RTL and testbench
==================================

// Module: mb_regfile_ctrl
// PURPOSE
//  Sequences Modbus register-block accesses onto one port of the holding-register DPRAM.
//  Executes one command at a time:
//   - read  (fn 0x03): fetch QTY words from ADDR, stream them out big-endian as bytes.
//   - write (fn 0x10): accept 2*QTY bytes, pack them into words, write them from ADDR.
//  Sits between the frame decoder/encoder and the DPRAM port A; port B stays with user logic.
// PARAMETERS
//  A_WIDTH   4     DPRAM address width; register space depth = 2**A_WIDTH words
//  D_WIDTH   16    DPRAM data width; must be 16 (Modbus register), others unsupported
// PORTS
//  CLOCK      in   1        single clock; all logic rising-edge
//  RESET_N    in   1        asynchronous, active-low reset
//  CMD_VALID  in   1        command offered
//  CMD_READY  out  1        high only in IDLE; command accepted when VALID&READY
//  CMD_WR     in   1        0=read (0x03), 1=write (0x10)
//  CMD_ADDR   in   16       starting register address from PDU
//  CMD_QTY    in   8        register count from PDU
//  ABORT      in   1        frame timeout/CRC fail; cancels current command
//  RD_DATA    out  8        read byte stream, high byte first
//  RD_VALID   out  1        RD_DATA valid; held stable until RD_READY
//  RD_READY   in   1        consumer accepts byte
//  WR_DATA    in   8        write byte stream, high byte first
//  WR_VALID   in   1        WR_DATA valid
//  WR_READY   out  1        controller accepts byte
//  DONE       out  1        one-cycle pulse: command finished (ok or exception)
//  EXC        out  1        qualifies DONE: 1=exception, EXC_CODE valid
//  EXC_CODE   out  8        0x02 illegal data address, 0x03 illegal data value
//  RAM_EN     out  1        DPRAM port enable
//  RAM_WE     out  1        DPRAM port write enable
//  RAM_ADDR   out  A_WIDTH  DPRAM address
//  RAM_DIN    out  16       DPRAM write data
//  RAM_DOUT   in   16       DPRAM read data, valid the cycle after RAM_EN (registered read)
// BEHAVIOUR
//  Reset: state IDLE; RD_VALID, WR_READY, DONE, EXC, RAM_EN, RAM_WE = 0;
//   RAM_ADDR, RAM_DIN, RD_DATA, EXC_CODE = 0; CMD_READY = 1.
//  Outputs are Moore (decoded from state/registers), never combinational from inputs.
//  IDLE:   CMD handshake latches WR/ADDR/QTY; IDX = 0; -> CHECK.
//  CHECK:  QTY==0, QTY>125 (read) or QTY>123 (write) -> EXC, code 0x03.
//          Else 17-bit ADDR+QTY > 2**A_WIDTH -> EXC, code 0x02.
//          Else -> RD_ISSUE (read) or WR_HI (write).
//          Value check has priority over the address check.
//  RD_ISSUE: RAM_EN=1, RAM_WE=0, RAM_ADDR = ADDR[A_WIDTH-1:0]+IDX -> RD_WAIT.
//  RD_WAIT:  WORD <= RAM_DOUT -> RD_HI.
//  RD_HI:    RD_VALID=1, RD_DATA=WORD[15:8]; on RD_READY -> RD_LO.
//  RD_LO:    RD_VALID=1, RD_DATA=WORD[7:0]; on RD_READY:
//            IDX==QTY-1 -> DONE, else IDX++ -> RD_ISSUE.
//  First RD_VALID is 4 cycles after the CMD handshake cycle; each word costs 2 cycles + 2 bytes.
//  WR_HI:    WR_READY=1; on WR_VALID WORD[15:8] <= WR_DATA -> WR_LO.
//  WR_LO:    WR_READY=1; on WR_VALID WORD[7:0] <= WR_DATA -> WR_COMMIT.
//  WR_COMMIT: RAM_EN=1, RAM_WE=1, RAM_ADDR=ADDR+IDX, RAM_DIN=WORD;
//            IDX==QTY-1 -> DONE, else IDX++ -> WR_HI.
//  DONE:     DONE=1, EXC=0 for one cycle -> IDLE.
//  EXC:      DONE=1, EXC=1, EXC_CODE held for one cycle -> IDLE. No RAM access for the command.
//  ABORT (any state except IDLE): next state IDLE; no DONE pulse; no further RAM access.
//   A RAM write in the ABORT cycle (WR_COMMIT) completes.
//   Words already committed remain.
//   ABORT in IDLE is ignored; ABORT outranks RD_READY/WR_VALID in the same cycle.
//  ADDR+IDX is computed in A_WIDTH bits; the CHECK state guarantees no wrap.
//  Async reset mid-command: immediate IDLE, partial writes remain, no DONE.
// STRUCTURE
//  Shared package mb_pkg: exception codes (0x02/0x03), max quantities (125/123),
//   state encoding constants.
//  Single flat FSM with IDX counter and WORD register; no sub-module.
//  The DPRAM is instanced alongside this block in the parent.
// TESTING (A_WIDTH=4, DPRAM behavioural model on RAM_* ports)
//  1. Read: RAM[3]=0x1234, RAM[4]=0xABCD; read ADDR=3 QTY=2
//     -> bytes 12,34,AB,CD; DONE with EXC=0; exactly 2 RAM_EN cycles.
//  2. Write: ADDR=13 QTY=3, bytes 01 02 03 04 05 06
//     -> RAM[13..15] = 0x0102, 0x0304, 0x0506; DONE with EXC=0.
//  3. Write ADDR=14 QTY=3 -> EXC=1, code 0x02, no RAM_EN.
//     QTY=0 -> code 0x03.
//     Read QTY=126 at ADDR=0 -> code 0x03.
//  4. Backpressure: in test 1, RD_READY held low 5 cycles in RD_HI
//     -> RD_DATA=0x12 and RD_VALID stable; no extra RAM_EN.
//  5. ABORT after first word of a QTY=2 write committed
//     -> word 1 written, word 2 not; no DONE; CMD_READY=1 next cycle.
//  6. RESET_N low during RD_LO -> all outputs at reset values immediately;
//     a new read command then completes correctly.

Source files
------------

// File: rtl/mb_pkg.sv
// mb_pkg: shared constants and state encoding for the Modbus register-block controller.
package mb_pkg;
  localparam logic [7:0] EXC_ADDR   = 8'h02;
  localparam logic [7:0] EXC_VALUE  = 8'h03;
  localparam logic [7:0] MAX_RD_QTY = 8'd125;
  localparam logic [7:0] MAX_WR_QTY = 8'd123;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD_ISSUE, S_RD_WAIT, S_RD_HI, S_RD_LO,
    S_WR_HI, S_WR_LO, S_WR_COMMIT, S_DONE, S_EXC
  } state_t;
endpackage

// File: rtl/mb_regfile_ctrl_if.sv
// mb_regfile_ctrl_if: command, byte streams, completion status and DPRAM port A.
interface mb_regfile_ctrl_if #(parameter int A_WIDTH = 4, parameter int D_WIDTH = 16);
  logic               cmd_valid, cmd_ready, cmd_wr;
  logic [15:0]        cmd_addr;
  logic [7:0]         cmd_qty;
  logic               abort;
  logic [7:0]         rd_data;
  logic               rd_valid, rd_ready;
  logic [7:0]         wr_data;
  logic               wr_valid, wr_ready;
  logic               done, exc;
  logic [7:0]         exc_code;
  logic               ram_en, ram_we;
  logic [A_WIDTH-1:0] ram_addr;
  logic [D_WIDTH-1:0] ram_din, ram_dout;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_qty, abort, rd_ready, wr_data, wr_valid, ram_dout,
    output cmd_ready, rd_data, rd_valid, wr_ready, done, exc, exc_code,
           ram_en, ram_we, ram_addr, ram_din
  );
  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_qty, abort, rd_ready, wr_data, wr_valid, ram_dout,
    input  cmd_ready, rd_data, rd_valid, wr_ready, done, exc, exc_code,
           ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/mb_regfile_ctrl.sv
// mb_regfile_ctrl: sequences Modbus read/write register blocks onto one DPRAM port.
module mb_regfile_ctrl
  import mb_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  mb_regfile_ctrl_if.slave bus
);
  localparam logic [16:0] DEPTH = 17'(1) << A_WIDTH;

  state_t             state, nxt;
  logic               wr;
  logic [15:0]        addr;
  logic [7:0]         qty, idx, code;
  logic [D_WIDTH-1:0] word;
  logic               bad_val, bad_addr, last;
  logic [A_WIDTH-1:0] ptr;

  assign bad_val  = qty == 8'd0 || qty > (wr ? MAX_WR_QTY : MAX_RD_QTY);
  assign bad_addr = 17'(addr) + 17'(qty) > DEPTH;
  assign last     = idx == qty - 8'd1;
  assign ptr      = addr[A_WIDTH-1:0] + idx[A_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr   <= 1'b0;
      addr <= '0;
      qty  <= '0;
      idx  <= '0;
      code <= '0;
      word <= '0;
    end else begin
      if (state == S_IDLE && bus.cmd_valid) begin
        wr   <= bus.cmd_wr;
        addr <= bus.cmd_addr;
        qty  <= bus.cmd_qty;
        idx  <= '0;
      end
      if (state == S_CHECK) code <= bad_val ? EXC_VALUE : EXC_ADDR;
      if (state == S_RD_WAIT) word <= bus.ram_dout;
      if (state == S_WR_HI && bus.wr_valid && !bus.abort) word[15:8] <= bus.wr_data;
      if (state == S_WR_LO && bus.wr_valid && !bus.abort) word[7:0] <= bus.wr_data;
      if (((state == S_RD_LO && bus.rd_ready) || state == S_WR_COMMIT) && !last) idx <= idx + 8'd1;
    end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      nxt = bus.cmd_valid ? S_CHECK : S_IDLE;
      S_CHECK:     nxt = (bad_val || bad_addr) ? S_EXC : wr ? S_WR_HI : S_RD_ISSUE;
      S_RD_ISSUE:  nxt = S_RD_WAIT;
      S_RD_WAIT:   nxt = S_RD_HI;
      S_RD_HI:     nxt = bus.rd_ready ? S_RD_LO : S_RD_HI;
      S_RD_LO:     nxt = bus.rd_ready ? (last ? S_DONE : S_RD_ISSUE) : S_RD_LO;
      S_WR_HI:     nxt = bus.wr_valid ? S_WR_LO : S_WR_HI;
      S_WR_LO:     nxt = bus.wr_valid ? S_WR_COMMIT : S_WR_LO;
      S_WR_COMMIT: nxt = last ? S_DONE : S_WR_HI;
      default:     nxt = S_IDLE;
    endcase
    // abort drops back to idle; a commit already on the port this cycle still lands
    if (bus.abort && state != S_IDLE) nxt = S_IDLE;
  end

  assign bus.cmd_ready = state == S_IDLE;
  assign bus.rd_valid  = state == S_RD_HI || state == S_RD_LO;
  assign bus.rd_data   = state == S_RD_HI ? word[15:8] : state == S_RD_LO ? word[7:0] : 8'h00;
  assign bus.wr_ready  = state == S_WR_HI || state == S_WR_LO;
  assign bus.done      = state == S_DONE || state == S_EXC;
  assign bus.exc       = state == S_EXC;
  assign bus.exc_code  = state == S_EXC ? code : 8'h00;
  assign bus.ram_en    = state == S_RD_ISSUE || state == S_WR_COMMIT;
  assign bus.ram_we    = state == S_WR_COMMIT;
  assign bus.ram_addr  = bus.ram_en ? ptr : '0;
  assign bus.ram_din   = bus.ram_we ? word : '0;
endmodule

// File: tb/tb_mb_regfile_ctrl.sv
// tb_mb_regfile_ctrl: directed vectors against a behavioural DPRAM on the RAM port.
module tb_mb_regfile_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_chk = 0, n_err = 0, en_cnt = 0, done_cnt = 0;
  int          e0, d0, lat;
  logic        stable;
  logic [15:0] mem [16];

  mb_regfile_ctrl_if #(.A_WIDTH(4), .D_WIDTH(16)) bus ();
  mb_regfile_ctrl #(.A_WIDTH(4), .D_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
      en_cnt <= en_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] q);
    int t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 20) begin @(negedge clk); t++; end
    chk("cmd_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_wr = w; bus.cmd_addr = a; bus.cmd_qty = q; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    int t = 0;
    bus.rd_ready = 1'b1;
    while (!bus.rd_valid && t < 20) begin @(negedge clk); t++; end
    chk({tag, "_valid"}, 32'(bus.rd_valid), 1);
    chk(tag, 32'(bus.rd_data), 32'(exp));
    @(posedge clk); #1 bus.rd_ready = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    int t = 0;
    bus.wr_data = d; bus.wr_valid = 1'b1;
    while (!bus.wr_ready && t < 20) begin @(negedge clk); t++; end
    chk("wr_ready", 32'(bus.wr_ready), 1);
    @(posedge clk); #1 bus.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic e, input logic [7:0] code);
    int t = 0;
    while (!bus.done && t < 40) begin @(negedge clk); t++; end
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_exc"}, 32'(bus.exc), 32'(e));
    chk({tag, "_code"}, 32'(bus.exc_code), 32'(code));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = 0; bus.cmd_qty = 0; bus.abort = 0;
    bus.rd_ready = 0; bus.wr_data = 0; bus.wr_valid = 0;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // preload RAM[3]=1234, RAM[4]=ABCD through the write path
    send(1'b1, 16'd3, 8'd2);
    wr_byte(8'h12); wr_byte(8'h34); wr_byte(8'hAB); wr_byte(8'hCD);
    wait_done("pre", 1'b0, 8'h00);
    chk("pre_mem3", 32'(mem[3]), 32'h1234);
    chk("pre_mem4", 32'(mem[4]), 32'hABCD);

    // read with 5 cycles of backpressure on the first byte
    e0 = en_cnt;
    send(1'b0, 16'd3, 8'd2);
    lat = 1;
    while (!bus.rd_valid && lat < 12) begin @(negedge clk); lat++; end
    chk("rd_latency", 32'(lat), 4);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h12) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 1);
    rd_byte("rd_b0", 8'h12); rd_byte("rd_b1", 8'h34);
    rd_byte("rd_b2", 8'hAB); rd_byte("rd_b3", 8'hCD);
    wait_done("rd", 1'b0, 8'h00);
    chk("rd_en_cycles", 32'(en_cnt - e0), 2);

    send(1'b1, 16'd13, 8'd3);
    wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
    wr_byte(8'h04); wr_byte(8'h05); wr_byte(8'h06);
    wait_done("wr", 1'b0, 8'h00);
    chk("wr_mem13", 32'(mem[13]), 32'h0102);
    chk("wr_mem14", 32'(mem[14]), 32'h0304);
    chk("wr_mem15", 32'(mem[15]), 32'h0506);

    send(1'b0, 16'd15, 8'd1);
    rd_byte("top_b0", 8'h05); rd_byte("top_b1", 8'h06);
    wait_done("top", 1'b0, 8'h00);

    e0 = en_cnt;
    send(1'b1, 16'd14, 8'd3);   wait_done("x_addr", 1'b1, 8'h02);
    send(1'b1, 16'd0, 8'd0);    wait_done("x_qty0", 1'b1, 8'h03);
    send(1'b0, 16'd0, 8'd126);  wait_done("x_rd126", 1'b1, 8'h03);
    send(1'b0, 16'd0, 8'd125);  wait_done("x_rd125", 1'b1, 8'h02);
    send(1'b1, 16'd0, 8'd124);  wait_done("x_wr124", 1'b1, 8'h03);
    send(1'b0, 16'h0100, 8'd1); wait_done("x_hiaddr", 1'b1, 8'h02);
    chk("x_no_ram", 32'(en_cnt - e0), 0);

    send(1'b1, 16'd9, 8'd1);
    wr_byte(8'h55); wr_byte(8'h66);
    wait_done("w9", 1'b0, 8'h00);

    // abort in the second word of a two-word write
    repeat (2) @(negedge clk);
    e0 = en_cnt; d0 = done_cnt;
    send(1'b1, 16'd8, 8'd2);
    wr_byte(8'hAA); wr_byte(8'hBB);
    @(negedge clk); @(negedge clk);
    bus.abort = 1'b1; bus.wr_data = 8'hCC; bus.wr_valid = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.wr_valid = 1'b0;
    chk("ab_cmd_ready", 32'(bus.cmd_ready), 1);
    repeat (4) @(negedge clk);
    chk("ab_en", 32'(en_cnt - e0), 1);
    chk("ab_no_done", 32'(done_cnt - d0), 0);
    chk("ab_mem8", 32'(mem[8]), 32'hAABB);
    chk("ab_mem9", 32'(mem[9]), 32'h5566);

    // async reset while the low byte is on offer
    d0 = done_cnt;
    send(1'b0, 16'd3, 8'd2);
    rd_byte("rs_b0", 8'h12);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_rd_valid", 32'(bus.rd_valid), 0);
    chk("rs_rd_data", 32'(bus.rd_data), 0);
    chk("rs_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rs_ram_en", 32'(bus.ram_en), 0);
    chk("rs_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 16'd3, 8'd2);
    rd_byte("rs2_b0", 8'h12); rd_byte("rs2_b1", 8'h34);
    rd_byte("rs2_b2", 8'hAB); rd_byte("rs2_b3", 8'hCD);
    wait_done("rs2", 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("rs_done_cnt", 32'(done_cnt - d0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
